// File: rtl/gi_kring.sv
// Round-key buffer: holds one expanded key schedule and streams it forward or reversed.
// Define GI_KRING_ZERO_EN to have reset and clear wipe every storage word.
module gi_kring #(
    parameter int KW    = 128,
    parameter int NRMAX = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          clear,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [KW-1:0] kin,
    input  logic          start,
    input  logic          dir,
    input  logic          next,
    input  logic          abort,
    output logic [KW-1:0] kout,
    output logic [3:0]    rnd,
    output logic          last,
    output logic          rdy
);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY, S_RUN} state_t;

    state_t        r_state;
    logic [3:0]    r_wcnt;
    logic [3:0]    r_ptr;
    logic [3:0]    r_rnd;
    logic [3:0]    r_nr;
    logic          r_dir;
    logic [KW-1:0] r_mem [0:NRMAX];

    logic [3:0]    w_mode_nr;
    logic          w_wr;
    logic [3:0]    w_waddr;
    logic          w_run;

    always_comb begin
        case (mode)
            2'd1:    w_mode_nr = 4'd12;
            2'd2:    w_mode_nr = 4'd14;
            default: w_mode_nr = 4'd10;
        endcase
    end

    assign w_wr    = load_valid && !clear && (r_state == S_EMPTY || r_state == S_LOAD);
    assign w_waddr = (r_state == S_LOAD) ? r_wcnt : 4'd0;
    assign w_run   = (r_state == S_RUN);

`ifdef GI_KRING_ZERO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NRMAX; i++) r_mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i <= NRMAX; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[w_waddr] <= kin;
        end
    end
`else
    // Storage is deliberately unreset; validity is tracked purely by the FSM.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_waddr] <= kin;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_wcnt  <= 4'd0;
            r_ptr   <= 4'd0;
            r_rnd   <= 4'd0;
            r_nr    <= 4'd10;
            r_dir   <= 1'b0;
        end else if (clear) begin
            r_state <= S_EMPTY;
            r_wcnt  <= 4'd0;
            r_ptr   <= 4'd0;
            r_rnd   <= 4'd0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (load_valid) begin
                        r_nr    <= w_mode_nr;
                        r_wcnt  <= 4'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        r_wcnt <= r_wcnt + 4'd1;
                        if (r_wcnt == r_nr) r_state <= S_READY;
                    end
                end
                S_READY: begin
                    if (start) begin
                        r_ptr   <= dir ? r_nr : 4'd0;
                        r_rnd   <= 4'd0;
                        r_dir   <= dir;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_rnd   <= 4'd0;
                        r_state <= S_READY;
                    end else if (next) begin
                        // The pointer holds on the final key so it never leaves 0..nr.
                        if (r_rnd == r_nr) begin
                            r_rnd   <= 4'd0;
                            r_state <= S_READY;
                        end else begin
                            r_ptr <= r_dir ? (r_ptr - 4'd1) : (r_ptr + 4'd1);
                            r_rnd <= r_rnd + 4'd1;
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign load_ready = (r_state == S_EMPTY) || (r_state == S_LOAD);
    assign rdy        = (r_state == S_READY);
    assign kout       = w_run ? r_mem[r_ptr] : '0;
    assign rnd        = r_rnd;
    assign last       = w_run && (r_rnd == r_nr);

endmodule
